idu_pipe: RTL
=============

Name: idu_pipe

Overview:
- Registered, parametrised decode stage: accepts fetched instructions over a valid/ready handshake and decodes them (controls, ALU op, register indices, sign-extended immediate, error/env flags).
- Decoded bundles are buffered in a DEPTH-entry FIFO and presented to execute over a second valid/ready handshake.
- Supports RV32I and RV64I via XLEN. Sits between fetch and execute, and absorbs execute back-pressure without stalling fetch until the FIFO is full.

Parameters:
- XLEN, 64, datapath width; 32 or 64. At 32, opcodes 0x3b/0x1b are illegal.
- INST_WIDTH, 32, instruction width.
- RF_SIZE, 5, register index width.
- DEPTH, 2, bundle FIFO entries; power of two, at least 2.
- ALUOP_W, 5, ALU opcode width. Bit 4 is used only by the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  discard all buffered bundles and any input accepted this cycle
- in_valid_i  in  1  fetch presents inst_i/pc_i
- in_ready_o  out  1  FIFO can accept
- inst_i  in  INST_WIDTH  instruction
- pc_i  in  XLEN  instruction address
- out_valid_o  out  1  head bundle valid
- out_ready_i  in  1  execute consumes head
- pc_o  out  XLEN  head PC
- enable_o  out  5  {MWRITE,MREAD,RD,RS2,RS1} (bit 4 down to 0)
- aluop_o  out  ALUOP_W  ALU opcode
- specinst_o  out  3  BR=0, JAL=1, JALR=2, AUIPC=3, LUI=4, NO_SPEC=5
- regi_o  out  3x RF_SIZE  [0]=rs1, [1]=rs2, [2]=rd
- detail_o  out  3  funct3
- imm_o  out  XLEN  sign-extended immediate
- decode_error_o  out  1  illegal encoding
- env_exception_o  out  2  [0]=ecall, [1]=ebreak

Behaviour:
- Reset (synchronous, clk edge with rst=1): FIFO empty; out_valid_o=0; in_ready_o=1 from the next cycle. All bundle outputs are 0 except specinst_o, which resets to NO_SPEC.
- Handshakes:
  - Push when in_valid_i && in_ready_o; pop when out_valid_o && out_ready_i.
  - in_ready_o = !full; it depends only on state, with no combinational path from out_ready_i.
  - When full, a simultaneous pop does not admit a push; that push is taken next cycle.
- Latency: a bundle pushed at edge N appears at the outputs after edge N (one cycle). There is no combinational input-to-output bypass.
- Ordering: strict FIFO. Count width is clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- Held outputs: while out_valid_o && !out_ready_i, every output stays stable. When empty, outputs hold the last popped bundle with out_valid_o=0.
- flush_i: on the next edge the FIFO is empty and any same-cycle push is dropped. flush_i has priority over push and pop; rst has priority over flush_i.
- Decode, computed combinationally on inst_i and registered at push:
  - Enables per opcode: R, R64 -> RS1,RS2,RD. I, I64 -> RS1,RD. Load -> RS1,RD,MREAD. Store -> RS1,RS2,MWRITE. Branch -> RS1,RS2. Jal -> RD. Jalr -> RS1,RD. Auipc, Lui -> RD. Env -> none.
  - ALU opcodes: ADD0 SUB1 OR2 AND3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9 COPY_B10 ADDW11 SUBW12 SLLW13 SRLW14 SRAW15.
  - R/I/R64/I64 funct3 mapping is standard. Shift-immediate arithmetic is selected by inst[30]. Branch EQ/NE -> SUB, LT/GE -> SLT, LTU/GEU -> SLTU. Load/Store/Jal/Jalr/Auipc -> ADD; Lui -> COPY_B.
  - Immediates: I-type inst[31:20]; S-type {inst[31:25],inst[11:7]}; B-type {inst[31],inst[7],inst[30:25],inst[11:8],0}; U-type {inst[31:12],12'b0}; J-type {inst[31],inst[19:12],inst[20],inst[30:21],0}. All sign-extended to XLEN. R-type and Env give 0.
- decode_error_o=1 for any of:
  - unknown opcode;
  - load funct3=111; store funct3 of 1xx;
  - branch funct3 010/011;
  - XLEN=32 with opcode 0x3b/0x1b;
  - XLEN=32 with load funct3 011/110 or store funct3 011;
  - XLEN=32 shift-immediate with inst[25]=1;
  - R-type funct7 not in {0x00, 0x20}, or 0x20 with a funct3 other than 000/101;
  - Env with funct12 not 0 or 1.
- An erroneous bundle is still enqueued, with enable_o=0 and aluop_o=ADD.

Optional Feature:
- Macro IDU_MEXT_EN.
- When defined: opcodes 0x33/0x3b with funct7=0x01 decode the M extension. They enable RS1,RS2,RD and set aluop_o = 16 + funct3 (MUL..REMU = 16..23). On 0x3b (valid only when XLEN=64), funct3 000/100/101/110/111 map to 24..28 (MULW, DIVW, DIVUW, REMW, REMUW).
- When undefined: funct7=0x01 is a decode error and aluop_o[4] is always 0.

Test Plan:
- Reset, then push 0x00500093 (addi x1,x0,5) at pc 0x80000000 with out_ready_i=1 -> one cycle later: out_valid_o=1, aluop_o=0, enable_o=5'b00101, regi_o[2]=1, imm_o=5, pc_o=0x80000000.
- Hold out_ready_i=0 and push 3 instructions with DEPTH=2 -> in_ready_o=0 after 2 pushes; outputs stable. Raise out_ready_i -> bundles drain in order, third accepted on the following cycle.
- Push beq with imm -4 (0xFE000EE3) -> specinst_o=0, aluop_o=1, imm_o=all-ones...FFFC.
- Buffer 2 bundles, assert flush_i together with in_valid_i -> next cycle out_valid_o=0, in_ready_o=1, nothing emitted.
- XLEN=32: push addw 0x002081BB -> decode_error_o=1, enable_o=0. XLEN=64 same input -> aluop_o=11, no error.
- Push ebreak 0x00100073 -> env_exception_o=2'b10, decode_error_o=0. Push 0x02208033 -> mul (aluop 16) if IDU_MEXT_EN, else decode_error_o=1.

Source files
------------

// File: rtl/idu_pipe.sv
// Decode stage: decodes fetched instructions and buffers the results in a DEPTH-entry FIFO for execute.
// Define IDU_MEXT_EN to add decoding of the M extension (funct7 = 0x01 on opcodes 0x33/0x3b).
module idu_pipe #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned RF_SIZE    = 5,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned ALUOP_W    = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [INST_WIDTH-1:0]       inst_i,
    input  logic [XLEN-1:0]             pc_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [XLEN-1:0]             pc_o,
    output logic [4:0]                  enable_o,
    output logic [ALUOP_W-1:0]          aluop_o,
    output logic [2:0]                  specinst_o,
    output logic [2:0][RF_SIZE-1:0]     regi_o,
    output logic [2:0]                  detail_o,
    output logic [XLEN-1:0]             imm_o,
    output logic                        decode_error_o,
    output logic [1:0]                  env_exception_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [6:0] OP_R = 7'h33, OP_R64 = 7'h3b, OP_I = 7'h13, OP_I64 = 7'h1b;
    localparam logic [6:0] OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_BR = 7'h63, OP_JAL = 7'h6f;
    localparam logic [6:0] OP_JALR = 7'h67, OP_AUIPC = 7'h17, OP_LUI = 7'h37, OP_ENV = 7'h73;

    localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_OR = 5'd2, A_AND = 5'd3, A_XOR = 5'd4;
    localparam logic [4:0] A_SLL = 5'd5, A_SRL = 5'd6, A_SRA = 5'd7, A_SLT = 5'd8, A_SLTU = 5'd9;
    localparam logic [4:0] A_COPYB = 5'd10, A_ADDW = 5'd11, A_SUBW = 5'd12, A_SLLW = 5'd13;
    localparam logic [4:0] A_SRLW = 5'd14, A_SRAW = 5'd15;

    localparam logic [2:0] S_BR = 3'd0, S_JAL = 3'd1, S_JALR = 3'd2, S_AUIPC = 3'd3;
    localparam logic [2:0] S_LUI = 3'd4, S_NONE = 3'd5;

    // enable bits {MWRITE,MREAD,RD,RS2,RS1}
    localparam logic [4:0] EN_RRR = 5'b00111, EN_RI = 5'b00101, EN_LD = 5'b01101;
    localparam logic [4:0] EN_ST = 5'b10011, EN_BR = 5'b00011, EN_RD = 5'b00100;

    typedef struct packed {
        logic [XLEN-1:0]         pc;
        logic [4:0]              en;
        logic [ALUOP_W-1:0]      alu;
        logic [2:0]              spec;
        logic [2:0][RF_SIZE-1:0] regi;
        logic [2:0]              detail;
        logic [XLEN-1:0]         imm;
        logic                    err;
        logic [1:0]              env;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign imm_i  = XLEN'($signed(inst_i[31:20]));
    assign imm_s  = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b  = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

    function automatic logic [4:0] alu_std(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_std = A_ADD;
            3'b001:  alu_std = A_SLL;
            3'b010:  alu_std = A_SLT;
            3'b011:  alu_std = A_SLTU;
            3'b100:  alu_std = A_XOR;
            3'b101:  alu_std = A_SRL;
            3'b110:  alu_std = A_OR;
            default: alu_std = A_AND;
        endcase
    endfunction

    logic [4:0] d_en;
    logic [4:0] d_alu;
    logic [2:0] d_spec;
    logic [XLEN-1:0] d_imm;
    logic d_err;
    logic [1:0] d_env;

    // Instruction decode; illegal encodings are flagged and stripped of enables.
    always_comb begin
        d_en   = '0;
        d_alu  = A_ADD;
        d_spec = S_NONE;
        d_imm  = '0;
        d_err  = 1'b0;
        d_env  = '0;
        case (opcode)
            OP_R: begin
                d_en = EN_RRR;
                if (funct7 == 7'h00) d_alu = alu_std(funct3);
                else if (funct7 == 7'h20 && funct3 == 3'b000) d_alu = A_SUB;
                else if (funct7 == 7'h20 && funct3 == 3'b101) d_alu = A_SRA;
`ifdef IDU_MEXT_EN
                else if (funct7 == 7'h01) d_alu = 5'd16 + {2'b00, funct3};
`endif
                else d_err = 1'b1;
            end
            OP_R64: begin
                d_en = EN_RRR;
                if (XLEN == 32) d_err = 1'b1;
                else if (funct7 == 7'h00 && funct3 == 3'b000) d_alu = A_ADDW;
                else if (funct7 == 7'h00 && funct3 == 3'b001) d_alu = A_SLLW;
                else if (funct7 == 7'h00 && funct3 == 3'b101) d_alu = A_SRLW;
                else if (funct7 == 7'h20 && funct3 == 3'b000) d_alu = A_SUBW;
                else if (funct7 == 7'h20 && funct3 == 3'b101) d_alu = A_SRAW;
`ifdef IDU_MEXT_EN
                else if (funct7 == 7'h01 && funct3 == 3'b000) d_alu = 5'd24;
                else if (funct7 == 7'h01 && funct3[2]) d_alu = 5'd25 + {3'b000, funct3[1:0]};
`endif
                else d_err = 1'b1;
            end
            OP_I: begin
                d_en  = EN_RI;
                d_imm = imm_i;
                d_alu = alu_std(funct3);
                if (funct3 == 3'b101 && inst_i[30]) d_alu = A_SRA;
                if (XLEN == 32 && funct3[1:0] == 2'b01 && inst_i[25]) d_err = 1'b1;
            end
            OP_I64: begin
                d_en  = EN_RI;
                d_imm = imm_i;
                if (XLEN == 32) d_err = 1'b1;
                else if (funct3 == 3'b000) d_alu = A_ADDW;
                else if (funct3 == 3'b001) d_alu = A_SLLW;
                else if (funct3 == 3'b101) d_alu = inst_i[30] ? A_SRAW : A_SRLW;
                else d_err = 1'b1;
            end
            OP_LOAD: begin
                d_en  = EN_LD;
                d_imm = imm_i;
                if (funct3 == 3'b111) d_err = 1'b1;
                if (XLEN == 32 && (funct3 == 3'b011 || funct3 == 3'b110)) d_err = 1'b1;
            end
            OP_STORE: begin
                d_en  = EN_ST;
                d_imm = imm_s;
                if (funct3[2] || (XLEN == 32 && funct3 == 3'b011)) d_err = 1'b1;
            end
            OP_BR: begin
                d_en   = EN_BR;
                d_spec = S_BR;
                d_imm  = imm_b;
                case (funct3[2:1])
                    2'b00:   d_alu = A_SUB;
                    2'b10:   d_alu = A_SLT;
                    2'b11:   d_alu = A_SLTU;
                    default: d_err = 1'b1;
                endcase
            end
            OP_JAL:   begin d_en = EN_RD; d_spec = S_JAL;   d_imm = imm_j; end
            OP_JALR:  begin d_en = EN_RI; d_spec = S_JALR;  d_imm = imm_i; end
            OP_AUIPC: begin d_en = EN_RD; d_spec = S_AUIPC; d_imm = imm_u; end
            OP_LUI:   begin d_en = EN_RD; d_spec = S_LUI;   d_imm = imm_u; d_alu = A_COPYB; end
            OP_ENV: begin
                if (inst_i[31:20] == 12'd0) d_env = 2'b01;
                else if (inst_i[31:20] == 12'd1) d_env = 2'b10;
                else d_err = 1'b1;
            end
            default: d_err = 1'b1;
        endcase
        if (d_err) begin
            d_en  = '0;
            d_alu = A_ADD;
        end
    end

    bundle_t dec_b;
    always_comb begin
        dec_b        = '0;
        dec_b.pc     = pc_i;
        dec_b.en     = d_en;
        dec_b.alu    = ALUOP_W'(d_alu);
        dec_b.spec   = d_spec;
        dec_b.regi   = {inst_i[11:7], inst_i[24:20], inst_i[19:15]};
        dec_b.detail = funct3;
        dec_b.imm    = d_imm;
        dec_b.err    = d_err;
        dec_b.env    = d_env;
    end

    bundle_t mem [DEPTH];
    bundle_t head_q, head_n;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic valid_q, ready_q, push, pop;

    // Next head: the oldest surviving entry, or the incoming bundle when it lands in an emptying FIFO.
    always_comb begin
        push   = in_valid_i && ready_q;
        pop    = valid_q && out_ready_i;
        cnt_n  = cnt + CNT_W'(push) - CNT_W'(pop);
        rd_n   = rd_ptr + PTR_W'(pop);
        head_n = head_q;
        if (cnt != CNT_W'(pop)) head_n = mem[rd_n];
        else if (push) head_n = dec_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            head_q      <= '0;
            head_q.spec <= S_NONE;
        end else if (flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            rd_ptr  <= rd_n;
            wr_ptr  <= wr_ptr + PTR_W'(push);
            cnt     <= cnt_n;
            valid_q <= (cnt_n != '0);
            ready_q <= (cnt_n != CNT_W'(DEPTH));
            head_q  <= head_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push) mem[wr_ptr] <= dec_b;
    end

    assign in_ready_o      = ready_q;
    assign out_valid_o     = valid_q;
    assign pc_o            = head_q.pc;
    assign enable_o        = head_q.en;
    assign aluop_o         = head_q.alu;
    assign specinst_o      = head_q.spec;
    assign regi_o          = head_q.regi;
    assign detail_o        = head_q.detail;
    assign imm_o           = head_q.imm;
    assign decode_error_o  = head_q.err;
    assign env_exception_o = head_q.env;
endmodule
